// File: rtl/tmds_channel_rx.sv
// TMDS receive lane: finds word alignment from control-token runs and asks the
// deserializer for bit-slips, then decodes each 10-bit word to DE/control/data.
module tmds_channel_rx #(
  parameter int RUN_LEN       = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 16,
  parameter int LOCK_TIMEOUT  = 4194304
) (
  input  logic       I_clk_pixel,
  input  logic       I_reset,
  input  logic [9:0] I_tmds_word,
  output logic       O_bitslip,
  output logic       O_locked,
  output logic       O_de,
  output logic [1:0] O_ctrl,
  output logic [7:0] O_data
);

  // The run counter must be able to hold RUN_LEN itself, not just RUN_LEN-1.
  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam int WIN_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int SET_W = (SLIP_SETTLE > 1) ? $clog2(SLIP_SETTLE) : 1;
  localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(RUN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SLIP_SETTLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t           state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             bitslip_q, locked_q;
  logic             de_q;
  logic [1:0]       ctrl_q;
  logic [7:0]       data_q;

  logic       is_ctrl;
  logic [1:0] tok;
  logic [7:0] data_dec;
  logic       run_hit;

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] qp;
    logic [7:0] d;
    qp   = q[9] ? ~q[7:0] : q[7:0];
    d[0] = qp[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
    end
    return d;
  endfunction

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    is_ctrl = 1'b1;
    tok     = 2'b00;
    case (I_tmds_word)
      10'b1101010100: tok = 2'b00;
      10'b0010101011: tok = 2'b01;
      10'b0101010100: tok = 2'b10;
      10'b1010101011: tok = 2'b11;
      default:        is_ctrl = 1'b0;
    endcase
  end

  assign data_dec = tmds_decode(I_tmds_word);

  // ctrl_q holds the last token seen; a non-zero run count means it was the previous word.
  always_comb begin
    run_cnt_d = '0;
    if (state_q != ST_SETTLE && is_ctrl) begin
      if (run_cnt_q != '0 && tok == ctrl_q) begin
        run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
      end else begin
        run_cnt_d = RUN_W'(1);
      end
    end
  end

  assign run_hit = (state_q != ST_SETTLE) && (run_cnt_d == RUN_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: only control/status flops are reset; there is no memory here to worry about.
  always_ff @(posedge I_clk_pixel or posedge I_reset) begin
    if (I_reset) begin
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
      data_q    <= 8'h00;
      run_cnt_q <= '0;
    end else begin
      de_q      <= ~is_ctrl;
      run_cnt_q <= run_cnt_d;
      if (is_ctrl) begin
        ctrl_q <= tok;
      end else begin
        data_q <= data_dec;
      end
    end
  end

  always_ff @(posedge I_clk_pixel or posedge I_reset) begin
    if (I_reset) begin
      state_q      <= ST_SEARCH;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          // A run hit on the last window cycle takes priority over the slip.
          if (run_hit) begin
            state_q   <= ST_LOCKED;
            locked_q  <= 1'b1;
            tmo_cnt_q <= '0;
          end else if (win_cnt_q == WIN_LAST) begin
            bitslip_q    <= 1'b1;
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q   <= ST_SEARCH;
            win_cnt_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (run_hit) begin
            tmo_cnt_q <= '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q   <= ST_SEARCH;
            locked_q  <= 1'b0;
            win_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign O_bitslip = bitslip_q;
  assign O_locked  = locked_q;
  assign O_de      = de_q;
  assign O_ctrl    = ctrl_q;
  assign O_data    = data_q;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed bench for tmds_channel_rx: decode, lock acquisition, slip timing,
// lock loss and async reset, with a rotating model deserializer for slips.
module tb_tmds_channel_rx;

  localparam int RUN_LEN       = 8;
  localparam int SEARCH_WINDOW = 2048;
  localparam int SLIP_SETTLE   = 16;
  localparam int LOCK_TIMEOUT  = 64;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DAT00 = 10'b0100000000;  // d = 8'h00
  localparam logic [9:0] DAT01 = 10'b0111111111;  // d = 8'h01
  localparam logic [9:0] DAT10 = 10'b1100001111;  // d = 8'h10
  localparam logic [9:0] DATAB = 10'b0000110011;  // d = 8'hAB

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] word;
  logic       bitslip, locked, de;
  logic [1:0] ctrl;
  logic [7:0] data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lock_cyc = -1;
  int slips[$];
  int rot = 0;
  bit use_model = 1'b0;

  tmds_channel_rx #(
    .RUN_LEN      (RUN_LEN),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .SLIP_SETTLE  (SLIP_SETTLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .I_clk_pixel(clk),
    .I_reset    (rst),
    .I_tmds_word(word),
    .O_bitslip  (bitslip),
    .O_locked   (locked),
    .O_de       (de),
    .O_ctrl     (ctrl),
    .O_data     (data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  function automatic int slip_at(input int i);
    return (i < slips.size()) ? slips[i] : -1;
  endfunction

  // Advance one cycle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    bit sl;
    sl = bitslip;
    @(posedge clk);
    #1;
    cyc++;
    if (use_model) begin
      if (sl) rot = (rot + 9) % 10;
      word = rotl(TOK10, rot);
    end
    if (bitslip) slips.push_back(cyc);
    if (locked && lock_cyc < 0) lock_cyc = cyc;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cyc      = 0;
    lock_cyc = -1;
    slips.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bitslip"}, bitslip, 0);
    check({tag, "_locked"},  locked,  0);
    check({tag, "_de"},      de,      0);
    check({tag, "_ctrl"},    ctrl,    0);
    check({tag, "_data"},    data,    0);
  endtask

  initial begin
    rst  = 1'b0;
    word = DAT01;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    release_reset();

    // Lock acquisition from 8 tokens of class 10.
    word = TOK10;
    repeat (RUN_LEN - 1) tick();
    check("lock_not_early", locked, 0);
    tick();
    check("lock_acq", locked, 1);
    check("lock_de", de, 0);
    check("lock_ctrl", ctrl, 2'b10);
    check("lock_no_slip", slips.size(), 0);

    // Decode sequence while locked.
    word = TOK00; tick();
    check("dec_tok_de", de, 0);
    check("dec_tok_ctrl", ctrl, 2'b00);
    word = DAT00; tick();
    check("dec_d00_de", de, 1);
    check("dec_d00_data", data, 8'h00);
    check("dec_d00_ctrl_hold", ctrl, 2'b00);
    word = DAT01; tick();
    check("dec_d01_data", data, 8'h01);
    word = DAT10; tick();
    check("dec_d10_data", data, 8'h10);
    word = DATAB; tick();
    check("dec_dab_data", data, 8'hAB);
    word = TOK11; tick();
    check("dec_tok11_de", de, 0);
    check("dec_tok11_ctrl", ctrl, 2'b11);
    check("dec_data_hold", data, 8'hAB);
    check("dec_still_locked", locked, 1);

    // Async reset mid-LOCKED, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_locked");
    release_reset();

    // Relock, then data only until the timeout drops lock.
    word = TOK10;
    repeat (RUN_LEN - 1) tick();
    check("relock_not_early", locked, 0);
    tick();
    check("relock", locked, 1);
    word = DAT01;
    while (cyc < RUN_LEN + LOCK_TIMEOUT - 1) tick();
    check("timeout_hold", locked, 1);
    tick();
    check("timeout_drop", locked, 0);
    check("timeout_no_slip", slips.size(), 0);
    while (cyc < RUN_LEN + LOCK_TIMEOUT + SEARCH_WINDOW - 1) tick();
    check("search_no_early_slip", slips.size(), 0);
    tick();
    check("slip_after_drop", bitslip, 1);

    // Async reset while the slip pulse is high.
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_slip");
    release_reset();

    // Misaligned stream through a model deserializer.
    use_model = 1'b1;
    rot  = 1;
    word = rotl(TOK10, rot);
    while (cyc < SEARCH_WINDOW + SLIP_SETTLE + RUN_LEN + 20) tick();
    use_model = 1'b0;
    check("mis_slip_count", slips.size(), 1);
    check("mis_slip_cycle", slip_at(0), SEARCH_WINDOW);
    check("mis_lock_cycle", lock_cyc, SEARCH_WINDOW + SLIP_SETTLE + RUN_LEN);
    check("mis_locked", locked, 1);

    // Broken runs: 7 x ctrl 00 then 1 x ctrl 01, never reaching RUN_LEN.
    rst = 1'b1;
    #1;
    release_reset();
    while (cyc < 6180) begin
      word = (cyc % 8 < 7) ? TOK00 : TOK01;
      tick();
    end
    check("broken_no_lock", lock_cyc, -1);
    check("broken_slip_count", slips.size(), 3);
    check("broken_slip0", slip_at(0), 2048);
    check("broken_slip1", slip_at(1), 4112);
    check("broken_slip2", slip_at(2), 6176);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
